// File: rtl/pool2d_stream.sv
// Streaming non-overlapping KxL pooling (avg/max/sum) over a row-major map, one partial-result row buffered.
// Latency: result valid on the edge after the window's last pixel; 1 pixel/cycle with no backpressure.
// Backpressure: a held result blocks DIN_RDY combinationally; results are never dropped.
module pool2d_stream #(
    parameter int INWIDTH   = 16,
    parameter int ACC_WIDTH = 28,
    parameter int MAX_W     = 128,
    parameter int DIM_WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        EN,
    input  logic                        START,
    input  logic        [1:0]           MODE,
    input  logic        [DIM_WIDTH-1:0] CFG_H,
    input  logic        [DIM_WIDTH-1:0] CFG_W,
    input  logic        [DIM_WIDTH-1:0] CFG_K,
    input  logic        [DIM_WIDTH-1:0] CFG_L,
    input  logic        [4:0]           CFG_SHIFT,
    input  logic signed [INWIDTH-1:0]   DIN,
    input  logic                        DIN_VLD,
    output logic                        DIN_RDY,
    output logic signed [INWIDTH-1:0]   DOUT,
    output logic                        DOUT_VLD,
    input  logic                        DOUT_RDY,
    output logic                        DOUT_OVFL,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        ERR
);
    localparam int CW  = $clog2(MAX_W);
    localparam int DW1 = DIM_WIDTH + 1;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2**(INWIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(INWIDTH-1)));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic [DIM_WIDTH-1:0]   h_q, w_q, k_q, l_q;
    logic [4:0]             shift_q;
    logic [DIM_WIDTH-1:0]   row_q, col_q, kr_q, lc_q;
    logic [CW-1:0]          c_q;
    logic signed [INWIDTH-1:0] dout_q;
    logic                   dout_vld_q, ovfl_q, busy_q, done_q, err_q;
    logic signed [ACC_WIDTH-1:0] pbuf_q [MAX_W];

    logic                   cfg_ok, accept, col_in, row_in, in_win, first, last;
    logic signed [ACC_WIDTH-1:0] din_ext, rd, acc_d;
    logic signed [ACC_WIDTH:0]   rnd, res;
    logic signed [INWIDTH-1:0]   sat_dat;
    logic                   sat_ovfl;

    assign cfg_ok = (MODE != 2'b00) && (CFG_K != '0) && (CFG_K <= CFG_H) &&
                    (CFG_L != '0) && (CFG_L <= CFG_W) && ({1'b0, CFG_W} <= DW1'(MAX_W));

    assign DIN_RDY = (state_q == S_RUN) && EN && (!dout_vld_q || DOUT_RDY);
    assign accept  = DIN_RDY && DIN_VLD;

    // A pixel counts only if the window it belongs to fits entirely inside the map.
    assign col_in = ({1'b0, col_q} - {1'b0, lc_q} + {1'b0, l_q}) <= {1'b0, w_q};
    assign row_in = ({1'b0, row_q} - {1'b0, kr_q} + {1'b0, k_q}) <= {1'b0, h_q};
    assign in_win = col_in && row_in;
    assign first  = (kr_q == '0) && (lc_q == '0);
    assign last   = (kr_q == k_q - DIM_WIDTH'(1)) && (lc_q == l_q - DIM_WIDTH'(1));

    assign din_ext = {{(ACC_WIDTH-INWIDTH){DIN[INWIDTH-1]}}, DIN};
    assign rd      = pbuf_q[c_q];

    always_comb begin
        acc_d = rd + din_ext;
        if (first)
            acc_d = din_ext;
        else if (mode_q == 2'b10)
            acc_d = (din_ext > rd) ? din_ext : rd;
    end

    always_comb begin
        rnd = {acc_d[ACC_WIDTH-1], acc_d};
        res = rnd;
        if (mode_q == 2'b01 && shift_q != 5'd0) begin
            rnd = {acc_d[ACC_WIDTH-1], acc_d} + ((ACC_WIDTH+1)'(1) << (shift_q - 5'd1));
            res = rnd >>> shift_q;
        end
        sat_ovfl = 1'b1;
        if (res > SAT_MAX)
            sat_dat = {1'b0, {(INWIDTH-1){1'b1}}};
        else if (res < SAT_MIN)
            sat_dat = {1'b1, {(INWIDTH-1){1'b0}}};
        else begin
            sat_dat  = res[INWIDTH-1:0];
            sat_ovfl = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && accept && in_win)
            pbuf_q[c_q] <= acc_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            h_q        <= '0;
            w_q        <= '0;
            k_q        <= '0;
            l_q        <= '0;
            shift_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            kr_q       <= '0;
            lc_q       <= '0;
            c_q        <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovfl_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (EN) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (dout_vld_q && DOUT_RDY)
                dout_vld_q <= 1'b0;
            if (accept && in_win && last) begin
                dout_q     <= sat_dat;
                ovfl_q     <= sat_ovfl;
                dout_vld_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        if (cfg_ok) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            mode_q  <= MODE;
                            h_q     <= CFG_H;
                            w_q     <= CFG_W;
                            k_q     <= CFG_K;
                            l_q     <= CFG_L;
                            shift_q <= CFG_SHIFT;
                            row_q   <= '0;
                            col_q   <= '0;
                            kr_q    <= '0;
                            lc_q    <= '0;
                            c_q     <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (col_q == w_q - DIM_WIDTH'(1)) begin
                            col_q <= '0;
                            lc_q  <= '0;
                            c_q   <= '0;
                            row_q <= row_q + DIM_WIDTH'(1);
                            kr_q  <= (kr_q == k_q - DIM_WIDTH'(1)) ? '0 : kr_q + DIM_WIDTH'(1);
                            if (row_q == h_q - DIM_WIDTH'(1))
                                state_q <= S_DRAIN;
                        end else begin
                            col_q <= col_q + DIM_WIDTH'(1);
                            if (lc_q == l_q - DIM_WIDTH'(1)) begin
                                lc_q <= '0;
                                c_q  <= c_q + CW'(1);
                            end else begin
                                lc_q <= lc_q + DIM_WIDTH'(1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!dout_vld_q || DOUT_RDY) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DOUT      = dout_q;
    assign DOUT_VLD  = dout_vld_q;
    assign DOUT_OVFL = ovfl_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: directed geometries plus random configs against a window-level reference model.
module tb_pool2d_stream;
    logic               CLK = 1'b0;
    logic               RESET, EN, START;
    logic [1:0]         MODE;
    logic [7:0]         CFG_H, CFG_W, CFG_K, CFG_L;
    logic [4:0]         CFG_SHIFT;
    logic signed [15:0] DIN;
    logic               DIN_VLD, DIN_RDY;
    logic signed [15:0] DOUT;
    logic               DOUT_VLD, DOUT_RDY, DOUT_OVFL, BUSY, DONE, ERR;

    int tests = 0;
    int fails = 0;
    int pix [256];
    int exp_d [$];
    int exp_o [$];

    always #5 CLK = ~CLK;

    pool2d_stream dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .START(START), .MODE(MODE),
        .CFG_H(CFG_H), .CFG_W(CFG_W), .CFG_K(CFG_K), .CFG_L(CFG_L), .CFG_SHIFT(CFG_SHIFT),
        .DIN(DIN), .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY),
        .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_RDY(DOUT_RDY), .DOUT_OVFL(DOUT_OVFL),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: pool each complete window from the pixel array, then round/saturate.
    task automatic build(input int mode, input int h, input int w, input int k, input int l, input int s);
        longint acc, v;
        exp_d.delete();
        exp_o.delete();
        for (int wr = 0; wr < h / k; wr++) begin
            for (int wc = 0; wc < w / l; wc++) begin
                acc = pix[wr * k * w + wc * l];
                for (int i = 0; i < k; i++) begin
                    for (int j = 0; j < l; j++) begin
                        if (i != 0 || j != 0) begin
                            v = pix[(wr * k + i) * w + wc * l + j];
                            if (mode == 2) acc = (v > acc) ? v : acc;
                            else acc = acc + v;
                        end
                    end
                end
                if (mode == 1 && s > 0) acc = (acc + (longint'(1) << (s - 1))) >>> s;
                if (acc > 32767) begin exp_d.push_back(32767); exp_o.push_back(1); end
                else if (acc < -32768) begin exp_d.push_back(-32768); exp_o.push_back(1); end
                else begin exp_d.push_back(int'(acc)); exp_o.push_back(0); end
            end
        end
    endtask

    task automatic run(input int mode, input int h, input int w, input int k, input int l, input int s,
                       input int rdy_pct, input int en_pct, input int abort_at, input string tag);
        int  idx;
        int  cyc;
        bit  done_seen;
        idx = 0;
        cyc = 0;
        done_seen = 1'b0;
        build(mode, h, w, k, l, s);
        @(negedge CLK);
        MODE = 2'(mode); CFG_H = 8'(h); CFG_W = 8'(w); CFG_K = 8'(k); CFG_L = 8'(l);
        CFG_SHIFT = 5'(s); START = 1'b1; EN = 1'b1; DOUT_RDY = 1'b1; DIN_VLD = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        #1;
        check({tag, " busy_after_start"}, BUSY, 1);
        check({tag, " rdy_after_start"}, DIN_RDY, 1);
        while (!done_seen && cyc < 4000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            EN       = ($urandom_range(0, 99) < en_pct);
            DOUT_RDY = ($urandom_range(0, 99) < rdy_pct);
            DIN_VLD  = (idx < h * w) && ($urandom_range(0, 9) < 9);
            DIN      = 16'(pix[idx]);
            #1;
            if (DONE) done_seen = 1'b1;
            if (DOUT_VLD && !DOUT_RDY) check({tag, " stall_rdy"}, DIN_RDY, 0);
            if (EN && DOUT_VLD && DOUT_RDY) begin
                if (exp_d.size() == 0) begin
                    check({tag, " extra_output"}, int'($signed(DOUT)), 99999);
                end else begin
                    check({tag, " dout"}, int'($signed(DOUT)), exp_d.pop_front());
                    check({tag, " ovfl"}, DOUT_OVFL, exp_o.pop_front());
                end
            end
            if (DIN_VLD && DIN_RDY) idx++;
            cyc++;
            @(negedge CLK);
        end
        EN = 1'b1;
        DIN_VLD = 1'b0;
        if (abort_at >= 0) begin
            check({tag, " no_done_before_reset"}, done_seen, 0);
            RESET = 1'b1;
            @(negedge CLK);
            RESET = 1'b0;
            #1;
            check({tag, " rst_din_rdy"}, DIN_RDY, 0);
            check({tag, " rst_dout_vld"}, DOUT_VLD, 0);
            check({tag, " rst_dout"}, int'(DOUT), 0);
            check({tag, " rst_ovfl"}, DOUT_OVFL, 0);
            check({tag, " rst_busy"}, BUSY, 0);
            check({tag, " rst_done"}, DONE, 0);
        end else begin
            check({tag, " done_seen"}, done_seen, 1);
            check({tag, " accepted"}, idx, h * w);
            check({tag, " missing_outputs"}, exp_d.size(), 0);
            check({tag, " busy_at_done"}, BUSY, 0);
            @(posedge CLK);
            #1;
            check({tag, " done_single_pulse"}, DONE, 0);
            check({tag, " idle_dout_vld"}, DOUT_VLD, 0);
        end
    endtask

    task automatic bad(input int mode, input int h, input int w, input int k, input int l, input string tag);
        @(negedge CLK);
        MODE = 2'(mode); CFG_H = 8'(h); CFG_W = 8'(w); CFG_K = 8'(k); CFG_L = 8'(l);
        CFG_SHIFT = 5'd0; START = 1'b1; EN = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        #1;
        check({tag, " err_pulse"}, ERR, 1);
        check({tag, " busy"}, BUSY, 0);
        check({tag, " din_rdy"}, DIN_RDY, 0);
        @(negedge CLK);
        #1;
        check({tag, " err_clear"}, ERR, 0);
        check({tag, " busy_later"}, BUSY, 0);
    endtask

    task automatic ramp16();
        for (int i = 0; i < 16; i++) pix[i] = i;
    endtask

    initial begin
        int h, w, k, l;
        RESET = 1'b1; EN = 1'b1; START = 1'b0; MODE = 2'b00;
        CFG_H = '0; CFG_W = '0; CFG_K = '0; CFG_L = '0; CFG_SHIFT = '0;
        DIN = '0; DIN_VLD = 1'b0; DOUT_RDY = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("reset din_rdy", DIN_RDY, 0);
        check("reset dout_vld", DOUT_VLD, 0);
        check("reset dout", int'(DOUT), 0);
        check("reset ovfl", DOUT_OVFL, 0);
        check("reset busy", BUSY, 0);
        check("reset done", DONE, 0);
        check("reset err", ERR, 0);

        ramp16();
        run(1, 4, 4, 2, 2, 2, 100, 100, -1, "avg4x4");

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) pix[r * 5 + c] = -(r * 5 + c);
        run(2, 5, 5, 2, 2, 0, 100, 100, -1, "max5x5");

        for (int i = 0; i < 4; i++) pix[i] = 28672;
        run(3, 2, 2, 2, 2, 0, 100, 100, -1, "sum_pos_sat");
        for (int i = 0; i < 4; i++) pix[i] = -28672;
        run(3, 2, 2, 2, 2, 0, 100, 100, -1, "sum_neg_sat");

        ramp16();
        run(1, 4, 4, 2, 2, 2, 30, 100, -1, "avg_backpressure");

        bad(1, 4, 4, 0, 2, "bad_k0");
        bad(1, 4, 4, 2, 5, "bad_l_gt_w");
        bad(1, 4, 129, 2, 2, "bad_w_gt_max");
        bad(0, 4, 4, 2, 2, "bad_mode0");

        ramp16();
        run(1, 4, 4, 2, 2, 2, 100, 100, 7, "abort");
        run(1, 4, 4, 2, 2, 2, 100, 100, -1, "after_abort");

        for (int t = 0; t < 8; t++) begin
            h = $urandom_range(1, 10);
            w = $urandom_range(1, 10);
            k = $urandom_range(1, h);
            l = $urandom_range(1, w);
            for (int i = 0; i < h * w; i++) pix[i] = int'($urandom_range(0, 65535)) - 32768;
            run($urandom_range(1, 3), h, w, k, l, $urandom_range(0, 4), 60, 80, -1, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
